// File: rtl/inst_mem_ctrl.sv
// Instruction memory with a clear/load/run controller: sweeps the array to zero,
// accepts a program over a valid/ready stream, then serves registered fetches.
module inst_mem_ctrl #(
  parameter int INST_SIZE = 16,
  parameter int PC_SIZE   = 13,
  parameter int DEPTH     = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [INST_SIZE-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic [PC_SIZE:0]     load_count,
  output logic                 load_ovf,
  output logic                 mem_ready,
  input  logic                 fetch_en,
  input  logic [PC_SIZE-1:0]   instr_mem_addr,
  output logic [INST_SIZE-1:0] instr,
  output logic                 instr_valid,
  output logic                 addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_SIZE:0] DEPTH_W = (PC_SIZE+1)'(DEPTH);
  localparam logic [PC_SIZE:0] LAST_W  = (PC_SIZE+1)'(DEPTH - 1);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PC_SIZE:0]     sweep_q, sweep_d;
  logic [PC_SIZE:0]     ptr_q, ptr_d;
  logic                 ovf_q, ovf_d;
  logic [INST_SIZE-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [INST_SIZE-1:0] mem_q [DEPTH];
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [INST_SIZE-1:0] wdata;
  logic                 in_range;

  assign in_range = {1'b0, instr_mem_addr} < DEPTH_W;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = err_q;
    we      = 1'b0;
    waddr   = sweep_q[AW-1:0];
    wdata   = '0;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = sweep_q[AW-1:0];
        if (sweep_q == LAST_W) begin
          state_d = S_LOAD;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          // A full array still accepts beats so the stream can reach its last flag.
          if (ptr_q == DEPTH_W) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = ptr_q[AW-1:0];
            wdata = load_data;
            ptr_d = ptr_q + 1'b1;
          end
          if (load_last) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fetch_en) begin
          valid_d = 1'b1;
          err_d   = ~in_range;
          instr_d = in_range ? mem_q[instr_mem_addr[AW-1:0]] : '0;
        end
        if (load_start) begin
          state_d = S_CLEAR;
          sweep_d = '0;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      sweep_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; the CLEAR sweep is its only initialisation.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign load_ready  = (state_q == S_LOAD);
  assign mem_ready   = (state_q == S_RUN);
  assign load_count  = ptr_q;
  assign load_ovf    = ovf_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl: fetch responses are queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_inst_mem_ctrl;
  localparam int IW = 16;
  localparam int PW = 13;
  localparam int D  = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic [PW:0]   load_count;
  logic          load_ovf;
  logic          mem_ready;
  logic          fetch_en = 1'b0;
  logic [PW-1:0] instr_mem_addr = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          addr_err;

  inst_mem_ctrl #(.INST_SIZE(IW), .PC_SIZE(PW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_count(load_count), .load_ovf(load_ovf), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .instr_mem_addr(instr_mem_addr), .instr(instr),
    .instr_valid(instr_valid), .addr_err(addr_err)
  );

  typedef struct {
    int          due;
    bit          v;
    logic [IW-1:0] d;
    bit          e;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [IW-1:0] last_d = '0;
  bit            last_e = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    exp_t x;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      x = sb.pop_front();
      n_chk++;
      if (instr_valid !== x.v || instr !== x.d || addr_err !== x.e) begin
        n_fail++;
        $display("FAIL fetch_resp@%0d: got v=%b instr=%h err=%b, want v=%b instr=%h err=%b",
                 cyc, instr_valid, instr, addr_err, x.v, x.d, x.e);
      end
    end else begin
      n_chk++;
      if (instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_valid@%0d: got instr_valid=%b, want 0", cyc, instr_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [PW-1:0] a, input logic [IW-1:0] d, input bit e);
    fetch_en = 1'b1;
    instr_mem_addr = a;
    sb.push_back('{cyc + 1, 1'b1, d, e});
    last_d = d;
    last_e = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    fetch_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{cyc + 1, 1'b0, last_d, last_e});
      @(negedge clk);
    end
  endtask

  task automatic beat(input logic [IW-1:0] d, input bit last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    @(negedge clk);
  endtask

  task automatic end_load();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  // Called at the falling edge just before the first sweep edge; fetches are
  // requested throughout and must be ignored.
  task automatic sweep_check();
    fetch_en = 1'b1;
    instr_mem_addr = '0;
    for (int k = 1; k <= D; k++) begin
      sb.push_back('{cyc + 1, 1'b0, last_d, last_e});
      @(negedge clk);
      chk("sweep_load_ready", 32'(load_ready), 32'(k == D));
      if (k < D) chk("sweep_mem_ready", 32'(mem_ready), 32'd0);
    end
    fetch_en = 1'b0;
    chk("sweep_load_count", 32'(load_count), 32'd0);
    chk("sweep_load_ovf", 32'(load_ovf), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outputs", {22'd0, load_ready, mem_ready, load_ovf, instr_valid, addr_err, 5'd0},
        32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    rst = 1'b1;
    sweep_check();

    // Three-beat program, then back-to-back fetches including one out of range.
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    chk("load2_count", 32'(load_count), 32'd2);
    chk("load2_mem_ready", 32'(mem_ready), 32'd0);
    beat(16'h3333, 1'b1);
    end_load();
    chk("load3_mem_ready", 32'(mem_ready), 32'd1);
    chk("load3_load_ready", 32'(load_ready), 32'd0);
    chk("load3_count", 32'(load_count), 32'd3);
    fetch(13'd0, 16'h1111, 1'b0);
    fetch(13'd1, 16'h2222, 1'b0);
    fetch(13'd2, 16'h3333, 1'b0);
    fetch(13'd5, 16'h0000, 1'b0);
    fetch(13'd24, 16'h0000, 1'b1);
    fetch(13'd2, 16'h3333, 1'b0);
    idle(2);
    chk("run_count", 32'(load_count), 32'd3);

    // Reload with a fetch in the same cycle as load_start.
    load_start = 1'b1;
    fetch(13'd1, 16'h2222, 1'b0);
    load_start = 1'b0;
    chk("reload_mem_ready", 32'(mem_ready), 32'd0);
    chk("reload_load_ready", 32'(load_ready), 32'd0);
    chk("reload_count", 32'(load_count), 32'd0);
    sweep_check();
    beat(16'hABCD, 1'b1);
    end_load();
    chk("reload_count1", 32'(load_count), 32'd1);
    chk("reload_run", 32'(mem_ready), 32'd1);
    fetch(13'd0, 16'hABCD, 1'b0);
    fetch(13'd1, 16'h0000, 1'b0);
    fetch(13'd23, 16'h0000, 1'b0);
    idle(1);

    // Overflow: 26 beats into 24 words.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    sweep_check();
    for (int i = 0; i < 26; i++) begin
      beat(16'h1000 + 16'(i), i == 25);
      if (i == 23) begin
        chk("ovf_full_count", 32'(load_count), 32'd24);
        chk("ovf_full_flag", 32'(load_ovf), 32'd0);
      end
      if (i == 24) begin
        chk("ovf_drop_flag", 32'(load_ovf), 32'd1);
        chk("ovf_drop_still_load", 32'(load_ready), 32'd1);
      end
    end
    end_load();
    chk("ovf_flag", 32'(load_ovf), 32'd1);
    chk("ovf_count", 32'(load_count), 32'd24);
    chk("ovf_run", 32'(mem_ready), 32'd1);
    fetch(13'd23, 16'h1017, 1'b0);
    fetch(13'd0, 16'h1000, 1'b0);
    fetch(13'd24, 16'h0000, 1'b1);
    idle(1);

    // Reset in the middle of a load.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("ovf_cleared", 32'(load_ovf), 32'd0);
    sweep_check();
    beat(16'h5555, 1'b0);
    beat(16'h6666, 1'b0);
    chk("midload_count", 32'(load_count), 32'd2);
    rst = 1'b0;
    #1;
    chk("midrst_flags", {27'd0, load_ready, mem_ready, load_ovf, instr_valid, addr_err}, 32'd0);
    chk("midrst_count", 32'(load_count), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    end_load();
    @(negedge clk);
    rst = 1'b1;
    last_d = '0;
    last_e = 1'b0;
    sweep_check();
    beat(16'h7777, 1'b1);
    end_load();
    chk("post_rst_count", 32'(load_count), 32'd1);
    fetch(13'd0, 16'h7777, 1'b0);
    fetch(13'd1, 16'h0000, 1'b0);
    idle(1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
